spike_rate_decoder: RTL

//  Receive-side companion to the LIF network: turns spike trains back into numbers.

---
 rtl/spike_rate_decoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes on parallel lines over a programmable
// window and hands out per-channel counts, saturation flags, the argmax
// channel and an any-spike flag over a valid/ready handshake.
module spike_rate_decoder #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [N_CH-1:0]         spike_in,
  input  logic [WIN_W-1:0]        win_len,
  output logic [N_CH*CNT_W-1:0]   rate_data,
  output logic [N_CH-1:0]         rate_sat,
  output logic [$clog2(N_CH)-1:0] winner,
  output logic                    any_spike,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  sat;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] cyc;

  logic [CNT_W-1:0]       cnt_next [N_CH];
  logic [N_CH-1:0]        sat_next;
  logic [N_CH*CNT_W-1:0]  data_next;
  logic [IDX_W-1:0]       winner_next;
  logic [CNT_W-1:0]       best_cnt;
  logic                   any_next;
  logic                   start_ok;
  logic                   last_cycle;

  assign start_ok   = ena && (win_len != '0);
  assign last_cycle = (cyc == win_reg - 1'b1);
  assign busy       = (state == S_COUNT);

  // Counts after this cycle's spikes: saturating increment, sticky sat flag
  always_comb begin
    data_next = '0;
    sat_next  = '0;
    any_next  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = cnt[i];
      if (spike_in[i] && (cnt[i] != CNT_MAX)) begin
        cnt_next[i] = cnt[i] + 1'b1;
      end
      sat_next[i] = sat[i] | (cnt_next[i] == CNT_MAX);
      data_next[i*CNT_W +: CNT_W] = cnt_next[i];
      any_next = any_next | (cnt_next[i] != '0);
    end
  end

  // Argmax over the final counts; strict compare keeps the lowest index on ties
  always_comb begin
    winner_next = '0;
    best_cnt    = cnt_next[0];
    for (int i = 1; i < N_CH; i++) begin
      if (cnt_next[i] > best_cnt) begin
        best_cnt    = cnt_next[i];
        winner_next = IDX_W'(i);
      end
    end
  end

  // Window FSM: IDLE waits for a start, COUNT accumulates, HOLD presents the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      win_reg    <= '0;
      cyc        <= '0;
      sat        <= '0;
      rate_data  <= '0;
      rate_sat   <= '0;
      winner     <= '0;
      any_spike  <= 1'b0;
      rate_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            win_reg <= win_len;
            cyc     <= '0;
            sat     <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            state   <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!ena) begin
            cyc   <= '0;
            sat   <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            state <= S_IDLE;
          end else begin
            sat <= sat_next;
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_next[i];
            if (last_cycle) begin
              rate_data  <= data_next;
              rate_sat   <= sat_next;
              winner     <= winner_next;
              any_spike  <= any_next;
              rate_valid <= 1'b1;
              state      <= S_HOLD;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (rate_ready) begin
            rate_valid <= 1'b0;
            if (start_ok) begin
              win_reg <= win_len;
              cyc     <= '0;
              sat     <= '0;
              for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
              state   <= S_COUNT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
